bin2bcd_seq: RTL and testbench

//  Sequential (shift-and-add-3, double-dabble) binary-to-BCD converter.

---
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 tb/tb_bin2bcd_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a start/done handshake.
// The bcd/overflow result register holds its value between conversions, so the display stays stable.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; result register holds the last value
// CONVERT | one add-3/shift step per cycle, WIDTH cycles in total
// DONE    | done pulse cycle; a new start is accepted here as well
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_sh;
    logic [BW-1:0]    dig_q;
    logic [BW-1:0]    dig_adj;
    logic [BW-1:0]    dig_sh;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;
    logic             carry;
    logic             accept;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (cnt_q == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? CONVERT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == CONVERT);
        accept = start && (state != CONVERT);
        last   = (state == CONVERT) && (cnt_q == CNT_LAST);
    end

    // Add-3 correction on each 4-bit digit, done before the shift so no digit leaves 0..9.
    always_comb begin
        dig_adj = dig_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        carry    = dig_adj[BW-1];
        dig_sh   = {dig_adj[BW-2:0], shift_q[WIDTH-1]};
        shift_sh = shift_q << 1;
    end

    // A bit shifted out of the top digit means the value no longer fits in DIGITS digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                shift_q <= bin;
                dig_q   <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else if (state == CONVERT) begin
                shift_q <= shift_sh;
                dig_q   <= dig_sh;
                cnt_q   <= cnt_q + CW'(1);
                ovf_q   <= ovf_q | carry;
                if (last) begin
                    bcd      <= dig_sh;
                    overflow <= ovf_q | carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: scoreboard of decimal-model results, checked on each done pulse.
module tb_bin2bcd_seq;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin = 8'd0;
    logic        busy, done, overflow;
    logic [11:0] bcd;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd2;

    int   n_assert = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   cyc_cnt = 0;
    exp_t sb[$];

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic exp_t model(input int v, input int digits);
        exp_t r;
        int   x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r.bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        r.ovf = (x != 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns at the first negedge after the accepting edge.
    task automatic start_conv(input logic [7:0] v);
        bin   = v;
        start = 1'b1;
        sb.push_back(model(int'(v), 3));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, pops the scoreboard and compares the result.
    task automatic wait_done(input string tag, output int lat, output int busy_n);
        exp_t e;
        int   n;
        n = 0;
        busy_n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            n++;
        end
        lat = n;
        chk({tag, "_done"}, 32'(done), 32'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_bcd"}, 32'(bcd), 32'(e.bcd));
            chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
        end else begin
            chk({tag, "_sb_empty"}, 32'(0), 32'(1));
        end
    endtask

    initial begin
        int lat, bn, d0, c0;
        exp_t e2;

        // reset
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_bcd", 32'(bcd), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1: zero
        start_conv(8'd0);
        wait_done("zero", lat, bn);
        chk("zero_lat", 32'(lat), 32'(WIDTH));
        @(negedge clk);
        chk("zero_done_low", 32'(done), 32'(0));

        // 2: all ones, latency and busy width
        @(negedge clk);
        start_conv(8'd255);
        chk("max_busy_first", 32'(busy), 32'(1));
        wait_done("max", lat, bn);
        chk("max_lat", 32'(lat), 32'(WIDTH));
        chk("max_busy_cycles", 32'(bn), 32'(WIDTH));
        chk("max_busy_at_done", 32'(busy), 32'(0));
        @(negedge clk);

        // 3: start and bin change mid-conversion are ignored
        d0 = done_cnt;
        start_conv(8'd99);
        @(negedge clk);
        bin   = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", lat, bn);
        chk("ign_lat", 32'(lat + 2), 32'(WIDTH));
        repeat (15) @(negedge clk);
        chk("ign_no_extra_done", 32'(done_cnt - d0), 32'(1));
        chk("ign_idle_busy", 32'(busy), 32'(0));

        // 4: start held high, back-to-back through DONE
        bin   = 8'd10;
        start = 1'b1;
        sb.push_back(model(10, 3));
        @(negedge clk);
        wait_done("b2b_a", lat, bn);
        chk("b2b_a_lat", 32'(lat), 32'(WIDTH));
        c0 = cyc_cnt;
        bin = 8'd128;
        sb.push_back(model(128, 3));
        @(negedge clk);
        chk("b2b_busy_again", 32'(busy), 32'(1));
        wait_done("b2b_b", lat, bn);
        chk("b2b_gap", 32'(cyc_cnt - c0), 32'(WIDTH + 1));
        start = 1'b0;
        @(negedge clk);
        chk("b2b_stop", 32'(busy), 32'(0));

        // 5: reset in the middle of a conversion
        @(negedge clk);
        d0 = done_cnt;
        start_conv(8'd200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_front());
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_bcd", 32'(bcd), 32'(0));
        chk("mid_rst_ovf", 32'(overflow), 32'(0));
        repeat (15) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'(0));

        // 6: two-digit instance, overflow then recovery
        start_conv(8'd200);
        wait_done("d2_200", lat, bn);
        e2 = model(200, 2);
        chk("d2_200_done", 32'(done2), 32'(1));
        chk("d2_200_bcd", 32'(bcd2), 32'(e2.bcd));
        chk("d2_200_ovf", 32'(overflow2), 32'(e2.ovf));
        @(negedge clk);
        start_conv(8'd42);
        wait_done("d2_42", lat, bn);
        e2 = model(42, 2);
        chk("d2_42_bcd", 32'(bcd2), 32'(e2.bcd));
        chk("d2_42_ovf", 32'(overflow2), 32'(e2.ovf));
        @(negedge clk);
        start_conv(8'd99);
        wait_done("d2_99", lat, bn);
        e2 = model(99, 2);
        chk("d2_99_bcd", 32'(bcd2), 32'(e2.bcd));
        chk("d2_99_ovf", 32'(overflow2), 32'(e2.ovf));
        @(negedge clk);
        start_conv(8'd100);
        wait_done("d2_100", lat, bn);
        e2 = model(100, 2);
        chk("d2_100_bcd", 32'(bcd2), 32'(e2.bcd));
        chk("d2_100_ovf", 32'(overflow2), 32'(e2.ovf));

        // a few extra values through the three-digit instance
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start_conv(8'($urandom_range(0, 255)));
            wait_done("rand", lat, bn);
            chk("rand_lat", 32'(lat), 32'(WIDTH));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
